ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive end of the team's one-hot ring counter.
- Samples a WIDTH-bit one-hot ring bus and encodes it to a binary phase index.
- Checks that the bus is a single legal one-hot and that each new sample is the rotate-left successor of the previous one.
- Acquires lock after a run of correct advances, then reports errors and counts full laps; used as a liveness/integrity monitor beside any ring counter.

Parameters:
WIDTH, 4, ring length in bits (>=2)
LOCK_COUNT, 4, consecutive correct advances required to assert locked (>=1)
CNT_W, 8, width of lap_count and err_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (0 = reset)
en  input  1  sample strobe; ring_in is evaluated only when 1
ring_in  input  WIDTH  one-hot ring bus under observation
index  output  $clog2(WIDTH)  binary position of the last legal sample
valid  output  1  last sample was exactly one-hot
locked  output  1  tracker is locked to the ring sequence
err  output  1  one-cycle pulse on a sequence error
lap_count  output  CNT_W  completed laps while locked
err_count  output  CNT_W  errors counted, saturating

Behaviour:
- Reset: when reset=0 at a clk edge, all of the following clear:
  - state=HUNT, index=0, valid=0, locked=0, err=0
  - lap_count=0, err_count=0, prev=0, run=0
- Reset has priority over en; a mid-lap reset discards lock and both counts.
- All outputs are registered, with 1-cycle latency from the sampling edge.
- en=0: state, prev, run, counts, index and valid hold; err=0.
- Legal sample: exactly one bit set; index = its bit position.
- An all-zero or multi-hot sample sets valid=0, and index holds its previous value.
- Successor: the expected next sample is {prev[WIDTH-2:0], prev[WIDTH-1]}; index advances by 1 mod WIDTH, wrapping WIDTH-1 -> 0.
- FSM, evaluated only when en=1:
  - HUNT:
    - Legal sample -> TRACK, prev=sample, run=0.
    - Illegal sample -> stay in HUNT, no err.
  - TRACK:
    - Correct successor -> run+1.
    - If run+1 == LOCK_COUNT -> LOCKED, and locked=1 from the next cycle.
    - Legal but not successor (skip, repeat, reverse) -> err pulse, run=0, prev=sample, stay in TRACK.
    - Illegal sample -> err pulse, go to HUNT.
  - LOCKED:
    - Correct successor -> stay in LOCKED.
    - Legal non-successor -> err pulse, go to TRACK with run=0.
    - Illegal sample -> err pulse, go to HUNT.
    - Leaving LOCKED clears locked on the same registered edge.
- prev updates on every legal sample.
- lap_count increments modulo 2^CNT_W on a correct wrap (prev bit WIDTH-1 -> sample bit 0), only if state was already LOCKED before the sample. The sample that achieves lock does not count a lap.
- err_count increments on every err pulse and saturates at all-ones.
- An error and a lap on the same sample are impossible by construction (a lap requires a correct successor).
- A repeated identical sample is an error; repeating 0001 is not a "hold".

Decomposition:
- Shared package ring_pkg holds:
  - state enum {HUNT, TRACK, LOCKED}
  - default WIDTH
  - an index-width helper constant/function
  - a rotate-left helper function, also reusable by ring_counter-family blocks
- One sub-module, onehot_to_bin:
  - Combinational WIDTH-bit one-hot to binary encoder.
  - Outputs index and an is_onehot flag.
  - Instantiated once; the FSM, counters and registers live in ring_decoder.

Test Plan:
1. Reset and hold: reset=0 for 2 cycles with ring_in=1111, en=1 -> index=0, valid=0, locked=0, err=0, both counts 0; release with en=0 -> all outputs unchanged.
2. Lock acquisition: WIDTH=4, LOCK_COUNT=4, en=1, drive 0001,0010,0100,1000,0001 on consecutive edges.
   - index reads 0,1,2,3,0 with valid=1.
   - locked=1 only after the 5th sample; lap_count=0.
3. Lap counting: continue from scenario 2 with 0010,0100,1000,0001 -> lap_count=1 after the final 0001, err_count=0; 8 further samples -> lap_count=3.
4. Skip error while locked: locked at 0010, drive 1000 -> err=1 for exactly one cycle, locked=0, err_count=1, index=3; then 0001,0010,0100,1000 -> locked=1 again.
5. Illegal pattern: while locked, drive 0110 -> valid=0, index holds, err pulse, state HUNT (locked=0); next 0001 -> valid=1, no err.
6. Saturation and en gating: CNT_W=2, force 5 errors -> err_count stays at 3; set en=0 while ring_in toggles randomly -> no err, no count or index change.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring counter family: FSM states, index width, rotation.
package ring_pkg;
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} ring_state_e;

  localparam int RING_W_DEF = 4;
  localparam int ROT_MAX_W  = 64;

  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Rotate the low w bits of v left by one; bits at and above w come back as zero.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] v, input int w);
    logic [ROT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < ROT_MAX_W; i++)
      if (i < w) r[(i + 1) % w] = v[i];
    return r;
  endfunction
endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder. The bin output is only meaningful when is_onehot is set.
module onehot_to_bin
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_W_DEF
) (
  input  logic [WIDTH-1:0]        onehot,
  output logic [idx_w(WIDTH)-1:0] bin,
  output logic                    is_onehot
);
  localparam int IW = idx_w(WIDTH);

  logic seen, multi;

  always_comb begin
    bin   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        bin   = bin | IW'(i);
      end
    end
    is_onehot = seen & ~multi;
  end
endmodule

// File: rtl/ring_decoder.sv
// Ring bus monitor: encodes the phase, checks rotate-left succession,
// locks after LOCK_COUNT good advances, then counts laps and errors.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH      = RING_W_DEF,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [WIDTH-1:0]        ring_in,
  output logic [idx_w(WIDTH)-1:0] index,
  output logic                    valid,
  output logic                    locked,
  output logic                    err,
  output logic [CNT_W-1:0]        lap_count,
  output logic [CNT_W-1:0]        err_count
);
  localparam int IW = idx_w(WIDTH);
  localparam int RW = $clog2(LOCK_COUNT + 1);

  ring_state_e     state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RW-1:0]   run_q, run_d, run_inc;
  logic [IW-1:0]   index_q, index_d, enc_idx;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] lap_q, lap_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic            is_oh, succ;
  logic [WIDTH-1:0] next_pat;

  onehot_to_bin #(.WIDTH(WIDTH)) u_enc (
    .onehot    (ring_in),
    .bin       (enc_idx),
    .is_onehot (is_oh)
  );

  assign next_pat = WIDTH'(rotl(ROT_MAX_W'(prev_q), WIDTH));
  assign succ     = is_oh && (ring_in == next_pat);
  assign run_inc  = run_q + RW'(1);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    index_d = index_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    lap_d   = lap_q;
    errc_d  = errc_q;
    if (en) begin
      valid_d = is_oh;
      if (is_oh) begin
        index_d = enc_idx;
        prev_d  = ring_in;
      end
      unique case (state_q)
        HUNT: begin
          if (is_oh) begin
            state_d = TRACK;
            run_d   = '0;
          end
        end
        TRACK: begin
          if (!is_oh) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (succ) begin
            run_d = run_inc;
            if (run_inc == RW'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            err_d = 1'b1;
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!is_oh) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (!succ) begin
            err_d   = 1'b1;
            state_d = TRACK;
            run_d   = '0;
          end else if (prev_q[WIDTH-1]) begin
            lap_d = lap_q + CNT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
      if (err_d && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= HUNT;
      prev_q   <= '0;
      run_q    <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      lap_q    <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      lap_q    <= lap_d;
      errc_q   <= errc_d;
    end
  end

  assign index     = index_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign lap_count = lap_q;
  assign err_count = errc_q;
endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed vector table, en-gating hold check, then random stimulus vs a reference model.
module tb_ring_decoder;
  localparam int W  = 4;
  localparam int LC = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  ring_in = '0;
  logic [1:0]    index;
  logic          valid, locked, err;
  logic [CW-1:0] lap_count, err_count;

  ring_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .ring_in   (ring_in),
    .index     (index),
    .valid     (valid),
    .locked    (locked),
    .err       (err),
    .lap_count (lap_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] ring;
    int         idx;
    int         vld;
    int         lck;
    int         er;
    int         lap;
    int         ec;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;
  int   errors = 0;
  int   checks = 0;

  // reference model state
  int m_state, m_prev, m_run, m_idx, m_vld, m_err, m_lap, m_ec;

  task automatic add(input logic r, input logic e, input logic [3:0] ring,
                     input int idx, input int vld, input int lck, input int er,
                     input int lap, input int ec);
    tbl[n_vec] = '{r, e, ring, idx, vld, lck, er, lap, ec};
    n_vec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [3:0] ring);
    reset   = r;
    en      = e;
    ring_in = ring;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input int vld, input int lck,
                         input int er, input int lap, input int ec);
    chk({tag, ".index"},     32'(index),     idx);
    chk({tag, ".valid"},     32'(valid),     vld);
    chk({tag, ".locked"},    32'(locked),    lck);
    chk({tag, ".err"},       32'(err),       er);
    chk({tag, ".lap_count"}, 32'(lap_count), lap);
    chk({tag, ".err_count"}, 32'(err_count), ec);
  endtask

  // States: 0 hunting, 1 tracking, 2 locked. Succession judged by phase arithmetic.
  task automatic model_step(input logic r, input logic e, input logic [3:0] ring);
    int pos;
    bit legal, good;
    m_err = 0;
    if (!r) begin
      m_state = 0; m_prev = 0; m_run = 0; m_idx = 0; m_vld = 0; m_lap = 0; m_ec = 0;
      return;
    end
    if (!e) return;
    legal = ($countones(ring) == 1);
    pos = 0;
    for (int i = 0; i < W; i++) if (ring[i]) pos = i;
    good = legal && (pos == (m_prev + 1) % W);
    m_vld = legal;
    if (legal) m_idx = pos;
    case (m_state)
      0: if (legal) begin m_state = 1; m_run = 0; end
      1: begin
        if (!legal) begin m_err = 1; m_state = 0; end
        else if (good) begin m_run++; if (m_run == LC) m_state = 2; end
        else begin m_err = 1; m_run = 0; end
      end
      default: begin
        if (!legal) begin m_err = 1; m_state = 0; end
        else if (!good) begin m_err = 1; m_state = 1; m_run = 0; end
        else if (m_prev == W - 1) m_lap = (m_lap + 1) % (1 << CW);
      end
    endcase
    if (legal) m_prev = pos;
    if (m_err && m_ec < (1 << CW) - 1) m_ec++;
  endtask

  initial begin
    logic [3:0] seq[4];
    logic       rr, ee;
    logic [3:0] rg;
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;

    // reset and hold
    add(0, 1, 4'b1111, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b1111, 0, 0, 0, 0, 0, 0);
    add(1, 0, 4'b1111, 0, 0, 0, 0, 0, 0);
    // lock acquisition
    add(1, 1, 4'b0001, 0, 1, 0, 0, 0, 0);
    add(1, 1, 4'b0010, 1, 1, 0, 0, 0, 0);
    add(1, 1, 4'b0100, 2, 1, 0, 0, 0, 0);
    add(1, 1, 4'b1000, 3, 1, 0, 0, 0, 0);
    add(1, 1, 4'b0001, 0, 1, 1, 0, 0, 0);
    // three laps
    for (int l = 1; l <= 3; l++)
      for (int s = 0; s < 4; s++)
        add(1, 1, seq[s], (s + 1) % 4, 1, 1, 0, (s == 3) ? l : l - 1, 0);
    // skip error while locked, then relock
    add(1, 1, 4'b0010, 1, 1, 1, 0, 3, 0);
    add(1, 1, 4'b1000, 3, 1, 0, 1, 3, 1);
    add(1, 1, 4'b0001, 0, 1, 0, 0, 3, 1);
    add(1, 1, 4'b0010, 1, 1, 0, 0, 3, 1);
    add(1, 1, 4'b0100, 2, 1, 0, 0, 3, 1);
    add(1, 1, 4'b1000, 3, 1, 1, 0, 3, 1);
    // wrap lap rolls 2-bit counter to 0, then illegal pattern
    add(1, 1, 4'b0001, 0, 1, 1, 0, 0, 1);
    add(1, 1, 4'b0110, 0, 0, 0, 1, 0, 2);
    add(1, 1, 4'b0001, 0, 1, 0, 0, 0, 2);
    // repeated samples are errors; err_count saturates at 3
    for (int k = 0; k < 5; k++)
      add(1, 1, 4'b0001, 0, 1, 0, 1, 0, 3);

    for (int v = 0; v < n_vec; v++) begin
      apply(tbl[v].rst, tbl[v].en, tbl[v].ring);
      chk_all($sformatf("vec%0d", v), tbl[v].idx, tbl[v].vld, tbl[v].lck,
              tbl[v].er, tbl[v].lap, tbl[v].ec);
    end

    // en=0 with a randomly toggling bus: everything holds, no err
    for (int k = 0; k < 8; k++) begin
      apply(1, 0, 4'($urandom));
      chk_all($sformatf("gate%0d", k), 0, 1, 0, 0, 0, 3);
    end
    apply(1, 1, 4'b0010);
    chk_all("gate_resume", 1, 1, 0, 0, 0, 3);

    // random stimulus against the reference model
    apply(0, 1, 4'b0000);
    model_step(0, 1, 4'b0000);
    chk_all("rnd_reset", m_idx, m_vld, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      rr = ($urandom_range(0, 59) != 0);
      ee = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) != 0) rg = 4'(1 << ((m_prev + 1) % W));
      else rg = 4'($urandom);
      apply(rr, ee, rg);
      model_step(rr, ee, rg);
      chk_all($sformatf("rnd%0d", k), m_idx, m_vld, (m_state == 2) ? 1 : 0,
              m_err, m_lap, m_ec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
